mmio_periph: RTL and testbench
==============================

# mmio_periph

Memory-mapped peripheral controller replacing the hard-wired LED/HEX write logic in the board top level. It sits beside the RAM on the CPU data bus and claims every access with the I/O select bit set. It provides:
- Parametrised LED and HEX registers with byte-masked writes and readback.
- A synchronised switch port with a sticky change flag.
- A 32-bit compare timer that raises an interrupt.

## Interface
- `NLEDS`, default 10: LED register width (≤32).
- `NDIGITS`, default 6: HEX digit count, 4 bits each (≤8).
- `NSW`, default 10: switch input width (≤31).
- `IO_SEL_BIT`, default 8: address bit marking an I/O access.

Ports:
- `clk` in 1: system clock.
- `reset` in 1: synchronous, active-high.
- `addr` in 32: CPU byte address.
- `writedata` in 32: store data.
- `memwrite` in 1: store strobe, one cycle per store.
- `writemask` in 4: byte enables for `writedata[8i+7:8i]`.
- `readdata` out 32: registered load data.
- `sw` in NSW: asynchronous board switches.
- `leds` out NLEDS: LED register.
- `hex_digits` out 4*NDIGITS: nibbles for the external `dec7seg` instances, digit 0 in `[3:0]`.
- `irq` out 1: timer interrupt, level, equals the pending bit.

## Operation
- Access is I/O when `addr[IO_SEL_BIT]`=1. Register selects are one-hot on `addr[7:2]`:
  - bit2 (0x104) LED
  - bit3 (0x108) HEX
  - bit4 (0x110) SW
  - bit5 (0x120) CNT
  - bit6 (0x140) CMP
  - bit7 (0x180) CTRL
- Writes go to every selected register; several bits set means several registers are written.
- Reads return the lowest-numbered selected register. No select bit set reads 0.
- All writes honour `writemask` per byte. Bits beyond a register's width are ignored on write and read as 0.
- SW register:
  - `sw` passes through two flops before use.
  - Read value is `{chg, 0…, sw_sync}`.
  - `chg` (bit31) sets when `sw_sync` differs from its previous value.
  - A read of SW clears `chg`. If a change and a clearing read occur in the same cycle, `chg` stays 1.
  - Writes to SW are ignored.
- Change detection is disarmed for 3 cycles after `reset` deasserts, while the synchroniser fills. A 2-bit arm counter controls this.
- CTRL bits:
  - bit0 EN
  - bit1 PEND, write-1-to-clear
  - bit2 AUTO
- Timer behaviour:
  - While EN=1, CNT increments by 1 each cycle, wrapping 0xFFFFFFFF→0.
  - When EN=1 and CNT==CMP, PEND sets on the next edge.
  - If AUTO=1 at a match, CNT loads 0 instead of CMP+1.
- Simultaneous events:
  - A CPU write to CNT wins over increment and reload.
  - The match compare uses the pre-write CNT.
  - A set of PEND wins over a W1C in the same cycle.

## Timing
- Reset values:
  - `leds`=0, `hex_digits`=0, `readdata`=0, `irq`=0
  - CNT=0, CMP=0xFFFFFFFF, CTRL=0
  - `chg`=0, sync flops=0
- Write latency: the register updates on the edge where `memwrite`=1. Outputs change the same edge.
- Read latency is 1 cycle: `readdata` is valid the cycle after `addr` is presented, matching the RAM.
- For non-I/O addresses `readdata` holds 0; the top muxes RAM/IO on the registered select.
- Timer sequence:
  - Match at edge N sets PEND at edge N.
  - `irq` is high from cycle N+1 and stays high until cleared.
  - With AUTO=1, the CNT sequence is …,CMP,0,1,…, giving a period of CMP+1 cycles.
- `sw` to `sw_sync` latency is 2 cycles. `chg` sets 1 cycle later.
- `reset` asserted mid-count returns every register to its reset value on that edge.

## Configuration
- `MMIO_TIMER_EN` defined: CNT/CMP/CTRL and `irq` are implemented as above.
- `MMIO_TIMER_EN` undefined:
  - No timer flops are synthesised.
  - Selects 5–7 read 0 and ignore writes.
  - `irq` is tied 0.
  - The LED/HEX/SW paths are unchanged.

## Test plan
- Reset, then store 0x3FF to 0x104 with mask 0001 → `leds`=0x0FF. Store again with mask 0011 → `leds`=0x3FF. Load from 0x104 → `readdata`=0x3FF one cycle later.
- Store 0x00ABCDEF to 0x108, mask 1111 → `hex_digits`=0xABCDEF. Store to 0x10C (selects LED and HEX) → both registers are written, and a load returns LED.
- `sw` changes 0x000→0x155 → SW reads 0x155 after 2 cycles. Bit31 is set 3 cycles after the change. A read clears it. A change in the same cycle as the read keeps it set.
- CMP=4, CTRL=0b101 → CNT runs 0,1,2,3,4,0,…. `irq` rises one cycle after CNT==4. Writing CTRL=0b111 clears PEND and keeps the timer running.
- CNT=0xFFFFFFFE, CMP=0x10, EN=1 → CNT wraps to 0 with no `irq` until it reaches 0x10. Asserting `reset` mid-run → CNT=0, CMP=0xFFFFFFFF, `irq`=0.
- Build without `MMIO_TIMER_EN` → load 0x120 returns 0, a store to 0x180 has no effect, and `irq` stays 0.

Source files
------------

// File: rtl/mmio_periph.sv
// mmio_periph: memory-mapped LED/HEX/switch registers and compare timer.
// Define MMIO_TIMER_EN to build the CNT/CMP/CTRL timer and its irq.
module mmio_periph #(
  parameter int NLEDS      = 10,
  parameter int NDIGITS    = 6,
  parameter int NSW        = 10,
  parameter int IO_SEL_BIT = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [31:0]          addr,
  input  logic [31:0]          writedata,
  input  logic                 memwrite,
  input  logic [3:0]           writemask,
  output logic [31:0]          readdata,
  input  logic [NSW-1:0]       sw,
  output logic [NLEDS-1:0]     leds,
  output logic [4*NDIGITS-1:0] hex_digits,
  output logic                 irq
);

  localparam int HW = 4 * NDIGITS;

  logic             io;
  logic [5:0]       sel;
  logic             wr;
  logic             rd;
  logic [NLEDS-1:0] led_nx;
  logic [HW-1:0]    hex_nx;
  logic [31:0]      led_w;
  logic [31:0]      hex_w;
  logic [31:0]      sw_w;
  logic [31:0]      rd_val;
  logic             sw_hit;
  logic [NSW-1:0]   sw_meta;
  logic [NSW-1:0]   sw_sync;
  logic [NSW-1:0]   sw_prev;
  logic             chg;
  logic [1:0]       arm;
  logic             armed;
  logic             chg_set;
  logic             chg_clr;
  logic             unused_bits;

  assign io  = addr[IO_SEL_BIT];
  assign sel = io ? addr[7:2] : 6'd0;
  assign wr  = memwrite & io;
  assign rd  = io & ~memwrite;

  assign unused_bits = ^{addr, writedata, writemask};

  function automatic logic [31:0] merge32(
    input logic [31:0] old,
    input logic [31:0] d,
    input logic [3:0]  m
  );
    logic [31:0] r;
    for (int i = 0; i < 4; i++)
      r[8*i +: 8] = m[i] ? d[8*i +: 8] : old[8*i +: 8];
    return r;
  endfunction

  // Byte-masked next values for the narrow LED and HEX registers
  always_comb begin
    led_nx = leds;
    hex_nx = hex_digits;
    for (int i = 0; i < NLEDS; i++)
      if (writemask[i/8]) led_nx[i] = writedata[i];
    for (int i = 0; i < HW; i++)
      if (writemask[i/8]) hex_nx[i] = writedata[i];
  end

  // Zero-extended read views of the narrow registers
  always_comb begin
    led_w = '0;
    hex_w = '0;
    sw_w  = '0;
    led_w[NLEDS-1:0] = leds;
    hex_w[HW-1:0]    = hex_digits;
    sw_w[NSW-1:0]    = sw_sync;
    sw_w[31]         = chg;
  end

  // LED and HEX registers
  always_ff @(posedge clk) begin
    if (reset) begin
      leds       <= '0;
      hex_digits <= '0;
    end else begin
      if (wr && sel[0]) leds <= led_nx;
      if (wr && sel[1]) hex_digits <= hex_nx;
    end
  end

  assign armed   = (arm == 2'd3);
  assign chg_set = armed && (sw_sync != sw_prev);
  assign chg_clr = rd && sw_hit;

  // Switch synchroniser, edge history, arm counter and sticky change flag
  always_ff @(posedge clk) begin
    if (reset) begin
      sw_meta <= '0;
      sw_sync <= '0;
      sw_prev <= '0;
      chg     <= 1'b0;
      arm     <= 2'd0;
    end else begin
      sw_meta <= sw;
      sw_sync <= sw_meta;
      sw_prev <= sw_sync;
      chg     <= chg_set | (chg & ~chg_clr);
      if (!armed) arm <= arm + 2'd1;
    end
  end

`ifdef MMIO_TIMER_EN
  logic [31:0] cnt;
  logic [31:0] cmp;
  logic        en;
  logic        pend;
  logic        auto;
  logic        match;
  logic        ctrl_wr;
  logic [31:0] ctrl_w;

  assign match   = en && (cnt == cmp);
  assign ctrl_wr = wr && sel[5] && writemask[0];
  assign ctrl_w  = {29'd0, auto, pend, en};
  assign irq     = pend;

  // Counter: CPU write beats reload, reload beats increment
  always_ff @(posedge clk) begin
    if (reset)
      cnt <= '0;
    else if (wr && sel[3])
      cnt <= merge32(cnt, writedata, writemask);
    else if (en)
      cnt <= (match && auto) ? 32'd0 : cnt + 32'd1;
  end

  // Compare register and control bits; a match beats a PEND clear
  always_ff @(posedge clk) begin
    if (reset) begin
      cmp  <= 32'hFFFF_FFFF;
      en   <= 1'b0;
      auto <= 1'b0;
      pend <= 1'b0;
    end else begin
      if (wr && sel[4])
        cmp <= merge32(cmp, writedata, writemask);
      if (ctrl_wr) begin
        en   <= writedata[0];
        auto <= writedata[2];
      end
      pend <= match | (pend & ~(ctrl_wr & writedata[1]));
    end
  end
`else
  assign irq = 1'b0;
`endif

  // Read mux: lowest-numbered selected register wins
  always_comb begin
    rd_val = '0;
    sw_hit = 1'b0;
    priority case (1'b1)
      sel[0]: rd_val = led_w;
      sel[1]: rd_val = hex_w;
      sel[2]: begin
        rd_val = sw_w;
        sw_hit = 1'b1;
      end
`ifdef MMIO_TIMER_EN
      sel[3]: rd_val = cnt;
      sel[4]: rd_val = cmp;
      sel[5]: rd_val = ctrl_w;
`endif
      default: rd_val = '0;
    endcase
  end

  // Registered load data, one cycle after the address
  always_ff @(posedge clk) begin
    if (reset) readdata <= '0;
    else       readdata <= rd_val;
  end

endmodule

// File: tb/tb_mmio_periph.sv
// tb_mmio_periph: vector table plus sequences for the switch flag and timer.
// Timer sequences follow the MMIO_TIMER_EN build of the design.
module tb_mmio_periph;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] addr = '0;
  logic [31:0] writedata = '0;
  logic        memwrite = 1'b0;
  logic [3:0]  writemask = '0;
  logic [31:0] readdata;
  logic [9:0]  sw = '0;
  logic [9:0]  leds;
  logic [23:0] hex_digits;
  logic        irq;

  int checks = 0;
  int failures = 0;

  mmio_periph dut (
    .clk(clk),
    .reset(reset),
    .addr(addr),
    .writedata(writedata),
    .memwrite(memwrite),
    .writemask(writemask),
    .readdata(readdata),
    .sw(sw),
    .leds(leds),
    .hex_digits(hex_digits),
    .irq(irq)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] a;
    logic [31:0] d;
    logic [3:0]  m;
    logic        we;
    logic [9:0]  e_leds;
    logic [23:0] e_hex;
    logic        chk_rd;
    logic [31:0] e_rd;
  } vec_t;

  vec_t vt[$];

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d,
                    input logic [3:0] m);
    addr = a;
    writedata = d;
    writemask = m;
    memwrite = 1'b1;
    cyc();
    memwrite = 1'b0;
    addr = '0;
    writedata = '0;
    writemask = '0;
  endtask

  task automatic rd(input logic [31:0] a, output logic [31:0] v);
    addr = a;
    cyc();
    v = readdata;
    addr = '0;
  endtask

  task automatic add(input logic [31:0] a, input logic [31:0] d,
                     input logic [3:0] m, input logic we,
                     input logic [9:0] el, input logic [23:0] eh,
                     input logic cr, input logic [31:0] er);
    vec_t v;
    v.a = a; v.d = d; v.m = m; v.we = we;
    v.e_leds = el; v.e_hex = eh; v.chk_rd = cr; v.e_rd = er;
    vt.push_back(v);
  endtask

  initial begin
    logic [31:0] v;
    logic [31:0] e;
    logic [31:0] sw_exp [5];
    logic [31:0] cnt_exp [7];

`ifdef MMIO_TIMER_EN
    logic [31:0] cmp_rst = 32'hFFFF_FFFF;
`else
    logic [31:0] cmp_rst = 32'h0;
`endif

    add(32'h104, 32'h3FF,       4'h1, 1, 10'h0FF, 24'h0,      0, 0);
    add(32'h104, 32'h3FF,       4'h3, 1, 10'h3FF, 24'h0,      0, 0);
    add(32'h104, 32'h0,         4'h0, 0, 10'h3FF, 24'h0,      1, 32'h3FF);
    add(32'h108, 32'h00ABCDEF,  4'hF, 1, 10'h3FF, 24'hABCDEF, 0, 0);
    add(32'h108, 32'h0,         4'h0, 0, 10'h3FF, 24'hABCDEF, 1, 32'hABCDEF);
    add(32'h10C, 32'h12345678,  4'hF, 1, 10'h278, 24'h345678, 0, 0);
    add(32'h10C, 32'h0,         4'h0, 0, 10'h278, 24'h345678, 1, 32'h278);
    add(32'h104, 32'hFFFFFC00,  4'hF, 1, 10'h000, 24'h345678, 0, 0);
    add(32'h104, 32'h0,         4'h0, 0, 10'h000, 24'h345678, 1, 32'h0);
    add(32'h108, 32'hFF000000,  4'h8, 1, 10'h000, 24'h345678, 0, 0);
    add(32'h108, 32'h0,         4'h0, 0, 10'h000, 24'h345678, 1, 32'h345678);
    add(32'h108, 32'h0,         4'h2, 1, 10'h000, 24'h340078, 0, 0);
    add(32'h108, 32'h0,         4'h0, 0, 10'h000, 24'h340078, 1, 32'h340078);
    add(32'h004, 32'hFFFFFFFF,  4'hF, 1, 10'h000, 24'h340078, 0, 0);
    add(32'h00C, 32'h0,         4'h0, 0, 10'h000, 24'h340078, 1, 32'h0);
    add(32'h100, 32'h0,         4'h0, 0, 10'h000, 24'h340078, 1, 32'h0);
    add(32'h110, 32'hFFFFFFFF,  4'hF, 1, 10'h000, 24'h340078, 0, 0);
    add(32'h110, 32'h0,         4'h0, 0, 10'h000, 24'h340078, 1, 32'h0);
    add(32'h120, 32'h0,         4'h0, 0, 10'h000, 24'h340078, 1, 32'h0);
    add(32'h140, 32'h0,         4'h0, 0, 10'h000, 24'h340078, 1, cmp_rst);
    add(32'h180, 32'h0,         4'h0, 0, 10'h000, 24'h340078, 1, 32'h0);
    add(32'h150, 32'h0,         4'h0, 0, 10'h000, 24'h340078, 1, 32'h0);

    sw_exp = '{32'h0, 32'h0, 32'h155, 32'h8000_0155, 32'h155};
    cnt_exp = '{32'd0, 32'd1, 32'd2, 32'd3, 32'd4, 32'd0, 32'd1};

    reset = 1'b1;
    cyc();
    cyc();
    chk("rst_leds", 32'(leds), 32'h0);
    chk("rst_hex", 32'(hex_digits), 32'h0);
    chk("rst_readdata", readdata, 32'h0);
    chk("rst_irq", 32'(irq), 32'h0);
    reset = 1'b0;
    cyc();
    cyc();

    for (int i = 0; i < vt.size(); i++) begin
      addr = vt[i].a;
      writedata = vt[i].d;
      writemask = vt[i].m;
      memwrite = vt[i].we;
      cyc();
      chk($sformatf("vec%0d_leds", i), 32'(leds), 32'(vt[i].e_leds));
      chk($sformatf("vec%0d_hex", i), 32'(hex_digits), 32'(vt[i].e_hex));
      if (vt[i].chk_rd)
        chk($sformatf("vec%0d_rd", i), readdata, vt[i].e_rd);
    end
    memwrite = 1'b0;
    addr = '0;
    writedata = '0;
    writemask = '0;
    cyc();

    // Switch change seen through a continuous SW read
    sw = 10'h155;
    addr = 32'h110;
    for (int k = 0; k < 5; k++) begin
      cyc();
      chk($sformatf("sw_seq%0d", k), readdata, sw_exp[k]);
    end
    addr = '0;
    cyc();

    // Reset with switches high: no spurious change flag once armed
    reset = 1'b1;
    cyc();
    chk("rst2_leds", 32'(leds), 32'h0);
    chk("rst2_hex", 32'(hex_digits), 32'h0);
    cyc();
    reset = 1'b0;
    for (int k = 0; k < 6; k++) cyc();
    rd(32'h110, v);
    chk("sw_arm_nochg", v, 32'h155);
    sw = 10'h0AA;
    for (int k = 0; k < 4; k++) cyc();
    rd(32'h110, v);
    chk("sw_chg_after_arm", v, 32'h8000_00AA);
    rd(32'h110, v);
    chk("sw_chg_cleared", v, 32'h0AA);

`ifdef MMIO_TIMER_EN
    wr(32'h140, 32'd4, 4'hF);
    wr(32'h180, 32'h5, 4'hF);
    addr = 32'h120;
    for (int k = 1; k <= 7; k++) begin
      cyc();
      chk($sformatf("auto_cnt%0d", k), readdata, cnt_exp[k-1]);
      chk($sformatf("auto_irq%0d", k), 32'(irq), 32'(k >= 5));
    end
    addr = '0;
    wr(32'h180, 32'h7, 4'hF);
    chk("w1c_irq", 32'(irq), 32'h0);
    rd(32'h120, v);
    chk("w1c_running", v, 32'd3);
    cyc();
    chk("auto_rematch_irq", 32'(irq), 32'h1);

    reset = 1'b1;
    cyc();
    reset = 1'b0;
    wr(32'h120, 32'hFFFF_FFFE, 4'hF);
    wr(32'h140, 32'h10, 4'hF);
    wr(32'h180, 32'h1, 4'hF);
    addr = 32'h120;
    for (int k = 1; k <= 22; k++) begin
      cyc();
      e = 32'hFFFF_FFFE + 32'(k - 1);
      chk($sformatf("wrap_cnt%0d", k), readdata, e);
      chk($sformatf("wrap_irq%0d", k), 32'(irq), 32'(k >= 19));
    end
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    addr = '0;
    chk("midrst_irq", 32'(irq), 32'h0);
    chk("midrst_rd", readdata, 32'h0);
    rd(32'h120, v);
    chk("midrst_cnt", v, 32'h0);
    rd(32'h140, v);
    chk("midrst_cmp", v, 32'hFFFF_FFFF);
    rd(32'h180, v);
    chk("midrst_ctrl", v, 32'h0);
`else
    wr(32'h140, 32'd4, 4'hF);
    wr(32'h120, 32'd4, 4'hF);
    wr(32'h180, 32'h5, 4'hF);
    for (int k = 0; k < 8; k++) begin
      cyc();
      chk($sformatf("notimer_irq%0d", k), 32'(irq), 32'h0);
    end
    rd(32'h120, v);
    chk("notimer_cnt", v, 32'h0);
    rd(32'h140, v);
    chk("notimer_cmp", v, 32'h0);
    rd(32'h180, v);
    chk("notimer_ctrl", v, 32'h0);
    chk("notimer_leds", 32'(leds), 32'h0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
